branch_resolve_stage: RTL and testbench

- Registered branch-resolution stage in the execute unit; sits directly downstream of the compare_gt comparator and instantiates it.
- Accepts decoded B-type branches with operand data, resolves taken/not-taken and the target, and drives a one-cycle front-end redirect.
- Squashes wrong-path beats for a fixed window after a taken branch, then hands the resolved record to the memory stage over a valid/ready handshake.

---
 rtl/branch_resolve_stage.sv | 195 +++++++++++++++++++
 tb/tb_branch_resolve_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_stage.sv
// branch_resolve_stage: registered branch-resolution stage of the execute unit.
// Resolves a decoded B-type branch, emits a one-cycle fetch redirect for
// taken branches, squashes wrong-path beats for FLUSH_CYCLES cycles, and
// hands the resolved record downstream over a valid/ready handshake.
// Optional build macro: BRANCH_PERF_CNT_EN adds saturating perf counters.

// compare_gt: a > b, signed or unsigned according to is_signed.
module compare_gt #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             gt
);

  // Select signed or unsigned magnitude comparison.
  always_comb begin
    if (is_signed) gt = $signed(a) > $signed(b);
    else           gt = a > b;
  end

endmodule

module branch_resolve_stage #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [2:0]       in_funct3,
  input  logic [WIDTH-1:0] in_rs1_data,
  input  logic [WIDTH-1:0] in_rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic             out_taken,
  output logic [WIDTH-1:0] out_target,
  output logic             out_illegal,
  output logic             out_misaligned,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_taken,
  output logic [31:0]      perf_squashed
`endif
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e           state;
  state_e           state_nxt;
  logic [3:0]       flush_cnt;

  logic             cmp_signed;
  logic             lt;
  logic             eq;
  logic             res_taken;
  logic             res_illegal;
  logic             res_misaligned;
  logic [WIDTH-1:0] res_target;

  logic             run_accept;
  logic             redirect_fire;

  // compare_gt is fed (rs2, rs1) so its gt output means rs1 < rs2.
  assign cmp_signed = !in_funct3[1];

  compare_gt #(.WIDTH(WIDTH)) u_cmp (
    .a         (in_rs2_data),
    .b         (in_rs1_data),
    .is_signed (cmp_signed),
    .gt        (lt)
  );

  assign eq             = (in_rs1_data == in_rs2_data);
  assign res_target     = in_pc + in_imm;
  assign res_misaligned = res_taken && (res_target[1:0] != 2'b00);

  // Decode funct3 into the branch condition; 010/011 are illegal, never taken.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    res_taken   = 1'b0;
    res_illegal = 1'b0;
    case (in_funct3)
      3'b000:         res_taken   = eq;
      3'b001:         res_taken   = !eq;
      3'b100, 3'b110: res_taken   = lt;
      3'b101, 3'b111: res_taken   = !lt;
      default:        res_illegal = 1'b1;
    endcase
  end

  // FSM state register and squash-window counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (redirect_fire)
        flush_cnt <= FLUSH_LOAD;
      else if (state == ST_FLUSH && flush_cnt != 4'd0)
        flush_cnt <= flush_cnt - 4'd1;
    end
  end

  // FSM next-state: enter FLUSH on a redirect, leave on the last squash cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (redirect_fire)       state_nxt = ST_FLUSH;
      ST_FLUSH: if (flush_cnt == 4'd1)   state_nxt = ST_RUN;
      default:                           state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs: handshake ready, RUN accept, and redirect decision.
  always_comb begin
    in_ready      = 1'b1;
    run_accept    = 1'b0;
    redirect_fire = 1'b0;
    case (state)
      ST_RUN: begin
        in_ready      = !out_valid || out_ready;
        run_accept    = in_valid && (!out_valid || out_ready);
        redirect_fire = run_accept && res_taken && !res_misaligned && !res_illegal;
      end
      default: in_ready = 1'b1;
    endcase
  end

  // Output record register: load on RUN accept, clear valid once drained.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here; rst is sampled only on the clock edge.
    if (rst) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_taken      <= 1'b0;
      out_target     <= '0;
      out_illegal    <= 1'b0;
      out_misaligned <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= redirect_fire;
      if (run_accept) begin
        out_valid      <= 1'b1;
        out_pc         <= in_pc;
        out_taken      <= res_taken;
        out_target     <= res_target;
        out_illegal    <= res_illegal;
        out_misaligned <= res_misaligned;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // The redirect address is the resolved target of the record just loaded.
  assign redirect_pc = out_target;

`ifdef BRANCH_PERF_CNT_EN
  logic squash_beat;
  assign squash_beat = (state == ST_FLUSH) && in_valid;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches <= '0;
      perf_taken    <= '0;
      perf_squashed <= '0;
    end else begin
      if (run_accept && perf_branches != 32'hFFFF_FFFF)
        perf_branches <= perf_branches + 32'd1;
      if (redirect_fire && perf_taken != 32'hFFFF_FFFF)
        perf_taken <= perf_taken + 32'd1;
      if (squash_beat && perf_squashed != 32'hFFFF_FFFF)
        perf_squashed <= perf_squashed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Self-checking bench for branch_resolve_stage: table-driven single-branch
// vectors plus hand-written flush, backpressure and reset sequences.
module tb_branch_resolve_stage;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_pc;
  logic [WIDTH-1:0] in_imm;
  logic [2:0]       in_funct3;
  logic [WIDTH-1:0] in_rs1_data;
  logic [WIDTH-1:0] in_rs2_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic             out_taken;
  logic [WIDTH-1:0] out_target;
  logic             out_illegal;
  logic             out_misaligned;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0]      perf_branches;
  logic [31:0]      perf_taken;
  logic [31:0]      perf_squashed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_resolve_stage #(.WIDTH(WIDTH), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_imm         (in_imm),
    .in_funct3      (in_funct3),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_taken      (out_taken),
    .out_target     (out_target),
    .out_illegal    (out_illegal),
    .out_misaligned (out_misaligned),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef BRANCH_PERF_CNT_EN
    ,
    .perf_branches  (perf_branches),
    .perf_taken     (perf_taken),
    .perf_squashed  (perf_squashed)
`endif
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        taken;
    logic [31:0] target;
    logic        illegal;
    logic        misal;
    logic        redir;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_funct3   = f3;
    in_pc       = pc;
    in_imm      = imm;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mkv(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic taken, input logic [31:0] target,
                               input logic illegal, input logic misal, input logic redir);
    vec_t v;
    v.f3 = f3; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
    v.taken = taken; v.target = target; v.illegal = illegal; v.misal = misal; v.redir = redir;
    return v;
  endfunction

  initial begin
    //             f3      pc            imm           rs1           rs2           tk  target        ill mis red
    vecs[0]  = mkv(3'b100, 32'h0000_0100, 32'h0000_0020, 32'hFFFF_FFF0, 32'h0000_0004, 1, 32'h0000_0120, 0, 0, 1); // BLT signed
    vecs[1]  = mkv(3'b110, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFF0, 32'h0000_0004, 0, 32'h0000_0240, 0, 0, 0); // BLTU
    vecs[2]  = mkv(3'b111, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFF0, 32'h0000_0004, 1, 32'h0000_0240, 0, 0, 1); // BGEU
    vecs[3]  = mkv(3'b101, 32'h0000_0280, 32'h0000_0008, 32'hFFFF_FFF0, 32'h0000_0004, 0, 32'h0000_0288, 0, 0, 0); // BGE signed
    vecs[4]  = mkv(3'b000, 32'h0000_0300, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1, 32'h0000_0310, 0, 0, 1); // BEQ
    vecs[5]  = mkv(3'b001, 32'h0000_0300, 32'h0000_0002, 32'h0000_0001, 32'h0000_0002, 1, 32'h0000_0302, 0, 1, 0); // BNE misaligned
    vecs[6]  = mkv(3'b010, 32'h0000_0340, 32'h0000_0004, 32'h0000_0005, 32'h0000_0005, 0, 32'h0000_0344, 1, 0, 0); // illegal 010
    vecs[7]  = mkv(3'b011, 32'h0000_0350, 32'h0000_0004, 32'h0000_0005, 32'h0000_0005, 0, 32'h0000_0354, 1, 0, 0); // illegal 011
    vecs[8]  = mkv(3'b000, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0010, 0, 0, 1); // target wrap
    vecs[9]  = mkv(3'b001, 32'h0000_0400, 32'hFFFF_FFF8, 32'h0000_0007, 32'h0000_0007, 0, 32'h0000_03F8, 0, 0, 0); // BNE equal
    vecs[10] = mkv(3'b100, 32'h0000_0500, 32'h0000_0010, 32'h0000_0004, 32'h0000_0004, 0, 32'h0000_0510, 0, 0, 0); // BLT equal
    vecs[11] = mkv(3'b101, 32'h0000_0500, 32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_0004, 1, 32'h0000_04FC, 0, 0, 1); // BGE equal
    vecs[12] = mkv(3'b110, 32'h0000_0600, 32'h0000_0100, 32'h7FFF_FFFF, 32'h8000_0000, 1, 32'h0000_0700, 0, 0, 1); // BLTU high bit

    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(3'b000, '0, '0, '0, '0);
    do_reset();

    // Reset state.
    check("rst_out_valid", out_valid, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_target", out_target, 0);

    // Table-driven single-branch vectors, each followed by enough idle cycles to leave FLUSH.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].f3, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].rs2);
      in_valid = 1'b1;
      #1;
      check($sformatf("v%0d_in_ready", i), in_ready, 1);
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_out_valid", i), out_valid, 1);
      check($sformatf("v%0d_out_pc", i), out_pc, vecs[i].pc);
      check($sformatf("v%0d_taken", i), out_taken, vecs[i].taken);
      check($sformatf("v%0d_target", i), out_target, vecs[i].target);
      check($sformatf("v%0d_illegal", i), out_illegal, vecs[i].illegal);
      check($sformatf("v%0d_misaligned", i), out_misaligned, vecs[i].misal);
      check($sformatf("v%0d_redirect_valid", i), redirect_valid, vecs[i].redir);
      if (vecs[i].redir)
        check($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].target);
      tick();
      check($sformatf("v%0d_redirect_pulse_end", i), redirect_valid, 0);
      check($sformatf("v%0d_drained", i), out_valid, 0);
      tick();
      tick();
    end

    // Squash window: taken BEQ, two wrong-path beats discarded, third beat resolved.
    drive(3'b000, 32'h0000_0400, 32'h0000_0010, 32'h0, 32'h0);
    in_valid = 1'b1;
    tick();
    check("fl_taken_valid", out_valid, 1);
    check("fl_redirect", redirect_valid, 1);
    check("fl_redirect_pc", redirect_pc, 32'h0000_0410);
    drive(3'b000, 32'h0000_0500, 32'h0000_0010, 32'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("fl_sq%0d_in_ready", k), in_ready, 1);
      tick();
      check($sformatf("fl_sq%0d_out_valid", k), out_valid, 0);
      check($sformatf("fl_sq%0d_redirect", k), redirect_valid, 0);
      check($sformatf("fl_sq%0d_out_pc", k), out_pc, 32'h0000_0400);
    end
    drive(3'b001, 32'h0000_0600, 32'h0000_0008, 32'h1, 32'h2);
    tick();
    in_valid = 1'b0;
    check("fl_third_valid", out_valid, 1);
    check("fl_third_pc", out_pc, 32'h0000_0600);
    check("fl_third_redirect", redirect_valid, 1);
    check("fl_third_redirect_pc", redirect_pc, 32'h0000_0608);
    tick(); tick(); tick();

    // Backpressure: hold for 3 cycles, then release together with a new beat.
    out_ready = 1'b0;
    drive(3'b110, 32'h0000_0700, 32'h0000_0004, 32'hFFFF_FFF0, 32'h4);
    in_valid = 1'b1;
    tick();
    check("bp_first_valid", out_valid, 1);
    drive(3'b000, 32'h0000_0800, 32'h0000_0004, 32'h1, 32'h2);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
      tick();
      check($sformatf("bp_hold%0d_valid", k), out_valid, 1);
      check($sformatf("bp_hold%0d_pc", k), out_pc, 32'h0000_0700);
      check($sformatf("bp_hold%0d_target", k), out_target, 32'h0000_0704);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_b2b_valid", out_valid, 1);
    check("bp_b2b_pc", out_pc, 32'h0000_0800);
    check("bp_b2b_taken", out_taken, 0);
    tick();
    check("bp_drained", out_valid, 0);
    tick();

    // out_ready low in FLUSH, then reset mid-FLUSH.
    out_ready = 1'b0;
    drive(3'b000, 32'h0000_0A00, 32'h0000_0040, 32'h0, 32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rf_redirect", redirect_valid, 1);
    #1;
    check("rf_flush_in_ready", in_ready, 1);
    tick();
    check("rf_hold_in_flush", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rf_out_valid", out_valid, 0);
    check("rf_redirect_valid", redirect_valid, 0);
    check("rf_in_ready", in_ready, 1);
    check("rf_out_pc", out_pc, 0);
    out_ready = 1'b1;
    drive(3'b000, 32'h0000_0900, 32'h0000_0008, 32'h3, 32'h3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rf_new_valid", out_valid, 1);
    check("rf_new_pc", out_pc, 32'h0000_0900);
    check("rf_new_redirect", redirect_valid, 1);
    check("rf_new_redirect_pc", redirect_pc, 32'h0000_0908);
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
